// File: rtl/huffman_pkg.sv
// Shared definitions for the Huffman front end: symbol codes, FSM encoding,
// default block geometry and the rank index type.
package huffman_pkg;

  localparam int HUF_NSYM  = 7;
  localparam int HUF_SYM_W = 4;
  localparam int HUF_CNT_W = 4;

  localparam logic [3:0] SYM_A = 4'hA;
  localparam logic [3:0] SYM_B = 4'hB;
  localparam logic [3:0] SYM_C = 4'hC;
  localparam logic [3:0] SYM_D = 4'hD;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_SORT  = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  typedef logic [1:0] rank_t;

endpackage

// File: rtl/huffman_cmp_swap.sv
// Combinational compare-swap of two ranked symbols keyed on (count, index);
// the larger key moves to the high slot, ties never swap.
module huffman_cmp_swap
  import huffman_pkg::*;
#(
  parameter int CNT_W = HUF_CNT_W
) (
  input  logic [CNT_W-1:0] lo_cnt,
  input  rank_t            lo_idx,
  input  logic [CNT_W-1:0] hi_cnt,
  input  rank_t            hi_idx,
  output rank_t            out_lo,
  output rank_t            out_hi
);

  logic swap;

  always_comb begin
    swap   = {lo_cnt, lo_idx} > {hi_cnt, hi_idx};
    out_lo = swap ? hi_idx : lo_idx;
    out_hi = swap ? lo_idx : hi_idx;
  end

endmodule

// File: rtl/huffman_count_ctrl.sv
// Counts the four legal symbols of a 7-symbol block, one per clock, then ranks
// them by ascending frequency; fixed NSYM+5 cycle latency from START to DONE.
module huffman_count_ctrl
  import huffman_pkg::*;
#(
  parameter int NSYM  = HUF_NSYM,
  parameter int SYM_W = HUF_SYM_W,
  parameter int CNT_W = HUF_CNT_W
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic [NSYM*SYM_W-1:0]   BLOCK_IN,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [4*CNT_W-1:0]      FREQ_OUT,
  output logic [7:0]              RANK_OUT,
  output logic                    ERR
);

  localparam int IDX_W = (NSYM > 4) ? $clog2(NSYM) : 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSYM - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t                  state, state_nxt;
  logic [NSYM*SYM_W-1:0]   shreg;
  logic [IDX_W-1:0]        idx;
  logic [CNT_W-1:0]        cnt [4];
  rank_t                   rank [4];
  logic                    err;

  logic [SYM_W-1:0]        cur_sym;
  logic                    sym_ok;
  rank_t                   sym_idx;

  always_comb begin
    cur_sym = shreg[SYM_W-1:0];
    sym_ok  = 1'b1;
    sym_idx = '0;
    if      (cur_sym == SYM_W'(SYM_A)) sym_idx = 2'd0;
    else if (cur_sym == SYM_W'(SYM_B)) sym_idx = 2'd1;
    else if (cur_sym == SYM_W'(SYM_C)) sym_idx = 2'd2;
    else if (cur_sym == SYM_W'(SYM_D)) sym_idx = 2'd3;
    else                               sym_ok  = 1'b0;
  end

  // During SORT the low bits of idx are the phase; odd phases reuse u_cs0 on (1,2).
  logic  odd_phase;
  rank_t u0_lo_in, u0_hi_in, u0_lo_out, u0_hi_out, u1_lo_out, u1_hi_out;

  assign odd_phase = idx[0];
  assign u0_lo_in  = odd_phase ? rank[1] : rank[0];
  assign u0_hi_in  = odd_phase ? rank[2] : rank[1];

  huffman_cmp_swap #(.CNT_W(CNT_W)) u_cs0 (
    .lo_cnt (cnt[u0_lo_in]),
    .lo_idx (u0_lo_in),
    .hi_cnt (cnt[u0_hi_in]),
    .hi_idx (u0_hi_in),
    .out_lo (u0_lo_out),
    .out_hi (u0_hi_out)
  );

  huffman_cmp_swap #(.CNT_W(CNT_W)) u_cs1 (
    .lo_cnt (cnt[rank[2]]),
    .lo_idx (rank[2]),
    .hi_cnt (cnt[rank[3]]),
    .hi_idx (rank[3]),
    .out_lo (u1_lo_out),
    .out_hi (u1_hi_out)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (START) state_nxt = ST_COUNT;
      ST_COUNT: if (idx == LAST_IDX) state_nxt = ST_SORT;
      ST_SORT:  if (idx[1:0] == 2'd3) state_nxt = ST_FIN;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shreg <= '0;
      idx   <= '0;
      err   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt[i]  <= '0;
        rank[i] <= rank_t'(i);
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            shreg <= BLOCK_IN;
            idx   <= '0;
            err   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
              cnt[i]  <= '0;
              rank[i] <= rank_t'(i);
            end
          end
        end
        ST_COUNT: begin
          shreg <= shreg >> SYM_W;
          idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
          if (!sym_ok)
            err <= 1'b1;
          else if (cnt[sym_idx] != CNT_MAX)
            cnt[sym_idx] <= cnt[sym_idx] + 1'b1;
        end
        ST_SORT: begin
          idx <= (idx[1:0] == 2'd3) ? '0 : idx + 1'b1;
          if (odd_phase) begin
            rank[1] <= u0_lo_out;
            rank[2] <= u0_hi_out;
          end else begin
            rank[0] <= u0_lo_out;
            rank[1] <= u0_hi_out;
            rank[2] <= u1_lo_out;
            rank[3] <= u1_hi_out;
          end
        end
        default: ;
      endcase
    end
  end

  assign BUSY     = (state != ST_IDLE);
  assign DONE     = (state == ST_FIN);
  assign FREQ_OUT = {cnt[3], cnt[2], cnt[1], cnt[0]};
  assign RANK_OUT = {rank[3], rank[2], rank[1], rank[0]};
  assign ERR      = err;

endmodule

// File: tb/tb_huffman_count_ctrl.sv
// Self-checking bench for huffman_count_ctrl: vector table, hand sequences and
// randomized blocks against a rank-by-counting reference model.
module tb_huffman_count_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [27:0] BLOCK_IN = '0;
  logic        BUSY, DONE, ERR;
  logic [15:0] FREQ_OUT;
  logic [7:0]  RANK_OUT;

  int tests = 0;
  int fails = 0;

  huffman_count_ctrl dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .BLOCK_IN (BLOCK_IN),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .FREQ_OUT (FREQ_OUT),
    .RANK_OUT (RANK_OUT),
    .ERR      (ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [27:0] blk;
    logic [15:0] freq;
    logic [7:0]  rank;
    logic        err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: count symbols, then each symbol's rank slot is the number of
  // symbols whose (count, index) key is strictly smaller.
  function automatic void model(input logic [27:0] blk, output logic [15:0] f,
                                output logic [7:0] r, output logic e);
    int c[4];
    logic [3:0] s;
    int pos;
    e = 1'b0;
    f = '0;
    r = '0;
    for (int i = 0; i < 4; i++) c[i] = 0;
    for (int k = 0; k < 7; k++) begin
      s = blk[k*4 +: 4];
      if (s >= 4'hA && s <= 4'hD) c[s - 4'hA]++;
      else e = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      pos = 0;
      for (int j = 0; j < 4; j++)
        if (c[j] < c[i] || (c[j] == c[i] && j < i)) pos++;
      r[pos*2 +: 2] = 2'(i);
      f[i*4 +: 4]   = 4'(c[i]);
    end
  endfunction

  // Launch one block; lat is the cycle index (1 = first COUNT cycle) at which DONE is seen.
  task automatic run_block(input logic [27:0] blk, output int lat);
    @(negedge CLK);
    BLOCK_IN = blk;
    START    = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    lat   = 1;
    while (!DONE && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
    end
  endtask

  task automatic check_block(input string name, input logic [27:0] blk,
                             input logic [15:0] f, input logic [7:0] r, input logic e);
    int lat;
    run_block(blk, lat);
    chk({name, " latency"}, lat, 12);
    chk({name, " freq"}, FREQ_OUT, f);
    chk({name, " rank"}, RANK_OUT, r);
    chk({name, " err"}, ERR, e);
    @(posedge CLK); #1;
    chk({name, " done pulse"}, DONE, 1'b0);
    chk({name, " busy end"}, BUSY, 1'b0);
  endtask

  initial begin
    vec_t        vecs[6];
    logic [27:0] blk;
    logic [15:0] mf;
    logic [7:0]  mr;
    logic        me;
    int          n_done;

    vecs[0] = '{28'hAAAAAAA, 16'h0007, 8'h39, 1'b0};
    vecs[1] = '{28'hBACDDBD, 16'h3121, 8'hD8, 1'b0};
    vecs[2] = '{28'h000000A, 16'h0001, 8'h39, 1'b1};
    vecs[3] = '{28'hDCBADCB, 16'h2221, 8'hE4, 1'b0};
    vecs[4] = '{28'hCCCCCCC, 16'h0700, 8'hB4, 1'b0};
    vecs[5] = '{28'hFFFFFFF, 16'h0000, 8'hE4, 1'b1};

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("reset busy", BUSY, 1'b0);
    chk("reset done", DONE, 1'b0);
    chk("reset err", ERR, 1'b0);
    chk("reset freq", FREQ_OUT, 16'h0000);
    chk("reset rank", RANK_OUT, 8'hE4);

    for (int i = 0; i < 6; i++)
      check_block($sformatf("vec%0d", i), vecs[i].blk, vecs[i].freq, vecs[i].rank, vecs[i].err);

    // START pulses during COUNT and FIN are ignored; START in the following IDLE cycle is taken.
    @(negedge CLK);
    BLOCK_IN = 28'hAAAAAAA;
    START    = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      START = (c == 5 || c == 12 || c == 13);
      if (c == 5)  BLOCK_IN = 28'hDDDDDDD;
      if (c == 13) BLOCK_IN = 28'hBACDDBD;
      chk($sformatf("b2b busy c%0d", c), BUSY, (c != 13 && c != 26));
      chk($sformatf("b2b done c%0d", c), DONE, (c == 12 || c == 25));
      if (c == 12) begin
        chk("b2b first freq", FREQ_OUT, 16'h0007);
        chk("b2b first rank", RANK_OUT, 8'h39);
      end
      if (c == 25) begin
        chk("b2b second freq", FREQ_OUT, 16'h3121);
        chk("b2b second rank", RANK_OUT, 8'hD8);
      end
      @(posedge CLK); #1;
    end
    START = 1'b0;
    repeat (2) @(posedge CLK);

    // Asynchronous reset in the middle of COUNT.
    @(negedge CLK);
    BLOCK_IN = 28'hAAAAAAA;
    START    = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (3) begin @(posedge CLK); #1; end
    chk("mid count freq", FREQ_OUT, 16'h0003);
    #2;
    RST = 1'b1;
    #1;
    chk("async rst busy", BUSY, 1'b0);
    chk("async rst done", DONE, 1'b0);
    chk("async rst err", ERR, 1'b0);
    chk("async rst freq", FREQ_OUT, 16'h0000);
    chk("async rst rank", RANK_OUT, 8'hE4);
    @(negedge CLK);
    RST = 1'b0;
    n_done = 0;
    repeat (20) begin
      @(posedge CLK); #1;
      if (DONE) n_done++;
    end
    chk("no done after rst", n_done, 0);
    check_block("post rst", 28'hDDDDDDD, 16'h7000, 8'hE4, 1'b0);

    // Randomized blocks, mostly legal symbols with occasional illegal codes.
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < 7; k++) begin
        int r;
        r = $urandom_range(0, 19);
        blk[k*4 +: 4] = (r < 16) ? 4'(10 + (r % 4)) : 4'($urandom_range(0, 15));
      end
      model(blk, mf, mr, me);
      check_block($sformatf("rand%0d", t), blk, mf, mr, me);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/huffman_count_ctrl.md
# huffman_count_ctrl

Sequencing controller for the Huffman front end. It accepts one packed block of seven 4-bit symbols and walks it through a per-symbol frequency count, one symbol per clock. It then ranks the four legal symbols (A=4'hA, B=4'hB, C=4'hC, D=4'hD) by ascending frequency and publishes the counts, the rank order and a done pulse. It sits between the symbol source and the tree builder, and gives the builder a deterministic latency and a sorted leaf list.

## Interface
- NSYM, 7: symbols per block.
- SYM_W, 4: bits per symbol.
- CNT_W, 4: bits per frequency counter; must be wide enough for NSYM.

- CLK  in  1  clock; all state is updated on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  launches processing of BLOCK_IN; only sampled in IDLE.
- BLOCK_IN  in  NSYM*SYM_W (28)  packed symbols; symbol 0 is in [3:0] and is consumed first.
- BUSY  out  1  high from the cycle after START is accepted through the DONE cycle.
- DONE  out  1  one-cycle pulse when the results are valid.
- FREQ_OUT  out  4*CNT_W (16)  counts packed as {D,C,B,A}.
- RANK_OUT  out  8  four 2-bit symbol indices (0=A … 3=D). [1:0] holds the least frequent symbol, [7:6] the most frequent.
- ERR  out  1  sticky flag: an illegal symbol was seen in the current block.

## Operation
- FSM states: IDLE, COUNT, SORT, FIN.
- IDLE:
  - On START=1, latch BLOCK_IN into a shift register.
  - Clear the four counters and ERR.
  - Load the rank registers with the identity order {3,2,1,0}.
  - Clear the symbol index and go to COUNT.
- COUNT: each cycle:
  - Decode the low nibble of the shift register.
  - A..D increments the matching counter. The counter saturates at 2^CNT_W-1; with the defaults it cannot overflow.
  - Any other code sets ERR and leaves all counters unchanged.
  - Shift right by SYM_W and increment the index.
  - After NSYM symbols, go to SORT.
- SORT: a 4-phase odd-even transposition sort, one phase per cycle.
  - Phases 0 and 2 compare-swap rank positions (0,1) and (2,3).
  - Phases 1 and 3 compare-swap positions (1,2).
  - Sort key is (count, symbol index), ascending. A swap happens only if the lower position has the strictly greater key, so ties keep the lower symbol index first.
  - After phase 3, go to FIN.
- FIN: DONE=1 for this single cycle, then return to IDLE.
- Output holding:
  - FREQ_OUT, RANK_OUT and ERR hold their values until the next accepted START.
  - During COUNT and SORT they show in-progress values. Consumers must qualify on DONE.
- START is ignored while in COUNT, SORT or FIN; a START level held through FIN is not re-accepted until the cycle after FIN.
- RST at any time, including mid-COUNT or mid-SORT, forces IDLE immediately. Any partial result is discarded.
- Reset values: BUSY=0, DONE=0, ERR=0, FREQ_OUT=16'h0000, RANK_OUT=8'hE4 (identity order).

## Timing
- START sampled high in IDLE at edge k:
  - COUNT spans cycles k+1..k+7.
  - SORT spans k+8..k+11.
  - DONE is high during cycle k+12.
  - BUSY is high during k+1..k+12.
  - IDLE is re-entered at k+13.
- Fixed latency of NSYM+5 cycles from START to DONE, independent of data.
- Back-to-back operation: the earliest next START is accepted at edge k+13, giving a throughput of one block per 13 cycles.

## Structure
- Shared package huffman_pkg holds:
  - symbol code constants SYM_A..SYM_D (4'hA..4'hD);
  - the FSM state encoding;
  - default NSYM, SYM_W and CNT_W;
  - the rank index type (2 bits).
- The front-end count block and the tree builder import the same package.
- One sub-module, huffman_cmp_swap: a combinational compare-swap on (count, index) pairs. It is instantiated twice for the even phases; one of those instances is reused for the odd phase.

## Test plan
- BLOCK_IN=28'hAAAAAAA, START pulse -> DONE exactly 12 cycles later; FREQ_OUT=16'h0007, RANK_OUT=8'h39, ERR=0.
- BLOCK_IN=28'hBACDDBD -> FREQ_OUT=16'h3121, RANK_OUT=8'hD8 (A,C,B,D; the A/C tie keeps A first), ERR=0.
- BLOCK_IN=28'h000000A -> ERR=1, FREQ_OUT=16'h0001, RANK_OUT=8'h39.
- Second START pulsed at k+5 and again at k+12 -> both ignored. A third START at k+13 is accepted and its DONE lands at k+25; BUSY is continuous except for its low cycle at k+13.
- RST asserted at k+4 mid-COUNT -> all outputs return to their reset values asynchronously and no DONE is produced. A fresh START with 28'hDDDDDDD -> FREQ_OUT=16'h7000, RANK_OUT=8'hE4.
- Reset-value check: immediately after RST deassertion, BUSY=0, DONE=0, ERR=0, FREQ_OUT=16'h0000, RANK_OUT=8'hE4.
